// File: rtl/sb_pkg.sv
// sb_pkg: shared types and constants for the register scoreboard.
//   NUM_REGS / REG_AW : register file geometry (16 registers, 4-bit index).
//   PEND_W / PEND_MAX : width and saturation value of each pending-write counter.
//   flush_state_e     : states of the post-jump issue-block FSM.
package sb_pkg;

    localparam int NUM_REGS = 16;
    localparam int REG_AW   = 4;
    localparam int PEND_W   = 2;

    typedef logic [REG_AW-1:0] reg_idx_t;
    typedef logic [PEND_W-1:0] pend_t;

    localparam pend_t PEND_MAX = '1;

    typedef enum logic {
        SB_IDLE,
        SB_FLUSH
    } flush_state_e;

endpackage

// File: rtl/sb_pend_counter.sv
// sb_pend_counter: outstanding-write counter for one architectural register.
//   clk, rst_n    : clock, asynchronous active-low reset
//   inc_i         : an accepted instruction targets this register
//   dec_i         : writeback commits this register
//   count_o       : current number of in-flight writes (registered)
//   underflow_o   : pulse, writeback arrived with no write outstanding
// Simultaneous inc and dec cancel, even at zero, and never flag underflow.
// Incrementing at PEND_MAX cannot happen: the issue hazard blocks it.
module sb_pend_counter
    import sb_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  inc_i,
    input  logic  dec_i,
    output pend_t count_o,
    output logic  underflow_o
);

    pend_t count_q;
    pend_t count_d;

    always_comb begin
        count_d     = count_q;
        underflow_o = 1'b0;
        case ({inc_i, dec_i})
            2'b10: count_d = count_q + pend_t'(1);
            2'b01: begin
                if (count_q != '0) begin
                    count_d = count_q - pend_t'(1);
                end else begin
                    underflow_o = 1'b1;
                end
            end
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: issue-side hazard controller for the 16 x 16-bit register file.
//   Parameter FLUSH_CYCLES (1..15): issue-block cycles after a taken jump.
//   Optional macro SB_WB_BYPASS_EN: a same-cycle writeback to a source register
//   is credited in the RAW test, so a reader can issue alongside its last writeback.
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   issue_valid / issue_ready        : issue handshake (see below)
//   issue_rs, issue_rt, issue_use_rt : source registers (rs always read)
//   issue_wr, issue_dst              : destination write of the instruction
//   stall                            : issue_valid & !issue_ready
//   wb_valid, wb_dst                 : writeback commit
//   jump_taken                       : taken jump resolved this cycle
//   flush_active                     : issue blocked by jump flush (FSM state)
//   busy_mask                        : bit i set while register i has writes in flight
//   err_underflow                    : sticky, writeback with nothing outstanding
// Handshake: an instruction transfers in a cycle where issue_valid and issue_ready
// are both high. issue_ready is combinational from registered state (plus the
// writeback inputs when bypass is enabled) and never depends on issue_valid.
// Decode holds the instruction stable while stall is high.
module reg_scoreboard
    import sb_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issue_valid,
    input  reg_idx_t            issue_rs,
    input  reg_idx_t            issue_rt,
    input  logic                issue_use_rt,
    input  logic                issue_wr,
    input  reg_idx_t            issue_dst,
    output logic                issue_ready,
    output logic                stall,
    input  logic                wb_valid,
    input  reg_idx_t            wb_dst,
    input  logic                jump_taken,
    output logic                flush_active,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic                err_underflow
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    pend_t               pend_cnt [NUM_REGS];
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;
    logic [NUM_REGS-1:0] uf_vec;
    logic                accept;
    logic                hazard;
    logic                rs_busy;
    logic                rt_busy;

    // ---------------- per-register counters ----------------
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_pend
        assign inc_vec[i]   = accept & issue_wr & (issue_dst == reg_idx_t'(i));
        assign dec_vec[i]   = wb_valid & (wb_dst == reg_idx_t'(i));
        assign busy_mask[i] = (pend_cnt[i] != '0);

        sb_pend_counter u_cnt (
            .clk         (clk),
            .rst_n       (rst_n),
            .inc_i       (inc_vec[i]),
            .dec_i       (dec_vec[i]),
            .count_o     (pend_cnt[i]),
            .underflow_o (uf_vec[i])
        );
    end

    // ---------------- hazard mux ----------------
`ifdef SB_WB_BYPASS_EN
    // Effective count = pend - same-cycle writeback; busy while it stays positive.
    always_comb begin
        rs_busy = pend_cnt[issue_rs] > pend_t'(wb_valid && (wb_dst == issue_rs));
        rt_busy = pend_cnt[issue_rt] > pend_t'(wb_valid && (wb_dst == issue_rt));
    end
`else
    always_comb begin
        rs_busy = (pend_cnt[issue_rs] != '0);
        rt_busy = (pend_cnt[issue_rt] != '0);
    end
`endif

    // The destination limit always uses the registered count: the counter
    // update itself never sees the bypass.
    assign hazard      = rs_busy | (issue_use_rt & rt_busy)
                       | (issue_wr & (pend_cnt[issue_dst] == PEND_MAX));
    assign issue_ready = ~hazard & ~flush_active;
    assign stall       = issue_valid & ~issue_ready;
    assign accept      = issue_valid & issue_ready;

    // ---------------- flush FSM ----------------
    flush_state_e state_q;
    flush_state_e state_d;
    logic [3:0]   flush_cnt_q;
    logic [3:0]   flush_cnt_d;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            SB_IDLE: begin
                if (jump_taken) begin
                    state_d     = SB_FLUSH;
                    flush_cnt_d = FLUSH_LOAD;
                end
            end
            SB_FLUSH: begin
                if (jump_taken) begin
                    flush_cnt_d = FLUSH_LOAD;
                end else if (flush_cnt_q == 4'd1) begin
                    state_d     = SB_IDLE;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d     = SB_IDLE;
                flush_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SB_IDLE;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign flush_active = (state_q == SB_FLUSH);

    // ---------------- sticky underflow error ----------------
    logic err_q;
    logic err_d;

    assign err_d = err_q | (|uf_vec);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_underflow = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: self-checking bench for reg_scoreboard (FLUSH_CYCLES=2).
// Reference model: per-register integer in-flight counts and a "blocked until
// cycle" number for jump flushes.
module tb_reg_scoreboard;

    localparam int FC   = 2;
    localparam int NR   = 16;
    localparam int PMAX = 3;

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic [3:0]  issue_rs;
    logic [3:0]  issue_rt;
    logic        issue_use_rt;
    logic        issue_wr;
    logic [3:0]  issue_dst;
    logic        issue_ready;
    logic        stall;
    logic        wb_valid;
    logic [3:0]  wb_dst;
    logic        jump_taken;
    logic        flush_active;
    logic [15:0] busy_mask;
    logic        err_underflow;

    int errors = 0;
    int checks = 0;

    // model state
    int pend_m [NR];
    bit err_m;
    int cyc;
    int block_until;

    reg_scoreboard #(.FLUSH_CYCLES(FC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_valid   (issue_valid),
        .issue_rs      (issue_rs),
        .issue_rt      (issue_rt),
        .issue_use_rt  (issue_use_rt),
        .issue_wr      (issue_wr),
        .issue_dst     (issue_dst),
        .issue_ready   (issue_ready),
        .stall         (stall),
        .wb_valid      (wb_valid),
        .wb_dst        (wb_dst),
        .jump_taken    (jump_taken),
        .flush_active  (flush_active),
        .busy_mask     (busy_mask),
        .err_underflow (err_underflow)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    task automatic m_reset();
        for (int i = 0; i < NR; i++) pend_m[i] = 0;
        err_m       = 1'b0;
        block_until = cyc - 1;
    endtask

    function automatic bit m_src_busy(int r);
        int eff;
        eff = pend_m[r];
`ifdef SB_WB_BYPASS_EN
        if (wb_valid && int'(wb_dst) == r) eff = eff - 1;
`endif
        return eff > 0;
    endfunction

    function automatic bit m_flush();
        return cyc <= block_until;
    endfunction

    function automatic bit m_ready();
        bit hz;
        hz = m_src_busy(int'(issue_rs))
           || (issue_use_rt && m_src_busy(int'(issue_rt)))
           || (issue_wr && pend_m[int'(issue_dst)] == PMAX);
        return !hz && !m_flush();
    endfunction

    function automatic logic [15:0] m_busy();
        logic [15:0] b;
        for (int i = 0; i < NR; i++) b[i] = (pend_m[i] > 0);
        return b;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_in(input int v, input int rs, input int rt, input int urt,
                          input int wr, input int dst, input int wbv, input int wbd,
                          input int jmp);
        issue_valid  = 1'(v);
        issue_rs     = 4'(rs);
        issue_rt     = 4'(rt);
        issue_use_rt = 1'(urt);
        issue_wr     = 1'(wr);
        issue_dst    = 4'(dst);
        wb_valid     = 1'(wbv);
        wb_dst       = 4'(wbd);
        jump_taken   = 1'(jmp);
        #2;
    endtask

    task automatic set_idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Advance one clock, updating the model from the inputs of this cycle.
    task automatic tick();
        bit acc;
        bit inc;
        bit dec;
        acc = issue_valid && m_ready();
        if (rst_n) begin
            for (int i = 0; i < NR; i++) begin
                inc = acc && issue_wr && int'(issue_dst) == i;
                dec = wb_valid && int'(wb_dst) == i;
                if (inc && !dec) begin
                    pend_m[i] = pend_m[i] + 1;
                end else if (dec && !inc) begin
                    if (pend_m[i] > 0) pend_m[i] = pend_m[i] - 1;
                    else err_m = 1'b1;
                end
            end
            if (jump_taken) block_until = cyc + FC;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic apply_reset();
        set_idle();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        set_in(1, 4, 5, 1, 1, 6, 0, 0, 0);
        checks++;
        if (busy_mask !== 16'h0000) begin
            errors++; $display("FAIL reset_busy got=%h exp=0000", busy_mask);
        end
        checks++;
        if (flush_active !== 1'b0) begin
            errors++; $display("FAIL reset_flush got=%b exp=0", flush_active);
        end
        checks++;
        if (err_underflow !== 1'b0) begin
            errors++; $display("FAIL reset_err got=%b exp=0", err_underflow);
        end
        checks++;
        if (issue_ready !== 1'b1 || stall !== 1'b0) begin
            errors++; $display("FAIL reset_ready got=%b/%b exp=1/0", issue_ready, stall);
        end
        set_idle();
    endtask

    task automatic test_raw();
        set_in(1, 1, 0, 0, 1, 3, 0, 0, 0);
        checks++;
        if (issue_ready !== 1'b1) begin
            errors++; $display("FAIL raw_wr_ready got=%b exp=1", issue_ready);
        end
        tick();
        set_in(1, 3, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (busy_mask !== 16'h0008) begin
            errors++; $display("FAIL raw_busy got=%h exp=0008", busy_mask);
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (stall !== 1'b1) begin
                errors++; $display("FAIL raw_stall cyc=%0d got=%b exp=1", k, stall);
            end
            tick();
        end
        set_in(1, 3, 0, 0, 0, 0, 1, 3, 0);
        checks++;
`ifdef SB_WB_BYPASS_EN
        if (stall !== 1'b0) begin
            errors++; $display("FAIL raw_wb_cycle_stall got=%b exp=0", stall);
        end
`else
        if (stall !== 1'b1) begin
            errors++; $display("FAIL raw_wb_cycle_stall got=%b exp=1", stall);
        end
`endif
        tick();
        set_in(1, 3, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (issue_ready !== 1'b1 || busy_mask !== 16'h0000) begin
            errors++;
            $display("FAIL raw_after_wb got ready=%b busy=%h exp ready=1 busy=0000",
                     issue_ready, busy_mask);
        end
        tick();
        set_idle();
    endtask

    task automatic test_waw();
        for (int k = 0; k < 3; k++) begin
            set_in(1, 0, 0, 0, 1, 5, 0, 0, 0);
            checks++;
            if (issue_ready !== 1'b1) begin
                errors++; $display("FAIL waw_issue%0d got=%b exp=1", k, issue_ready);
            end
            tick();
        end
        set_in(1, 0, 0, 0, 1, 5, 0, 0, 0);
        checks++;
        if (stall !== 1'b1 || busy_mask !== 16'h0020) begin
            errors++; $display("FAIL waw_sat got stall=%b busy=%h exp 1/0020", stall, busy_mask);
        end
        set_in(1, 0, 0, 0, 1, 5, 1, 5, 0);
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL waw_sat_wb_cycle got=%b exp=1", stall);
        end
        tick();
        set_in(1, 0, 0, 0, 1, 5, 0, 0, 0);
        checks++;
        if (issue_ready !== 1'b1) begin
            errors++; $display("FAIL waw_fourth got=%b exp=1", issue_ready);
        end
        tick();
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL waw_back_at_max got=%b exp=1", stall);
        end
        for (int k = 0; k < 3; k++) begin
            set_in(0, 0, 0, 0, 0, 0, 1, 5, 0);
            tick();
        end
        set_idle();
        checks++;
        if (busy_mask !== 16'h0000 || err_underflow !== 1'b0) begin
            errors++;
            $display("FAIL waw_drain got busy=%h err=%b exp 0000/0", busy_mask, err_underflow);
        end
    endtask

    task automatic test_same_cycle();
        set_in(1, 0, 0, 0, 1, 7, 0, 0, 0);
        tick();
        set_in(1, 0, 0, 0, 1, 7, 1, 7, 0);
        checks++;
        if (issue_ready !== 1'b1) begin
            errors++; $display("FAIL same_ready got=%b exp=1", issue_ready);
        end
        tick();
        set_in(1, 0, 0, 0, 1, 8, 1, 8, 0);
        checks++;
        if (busy_mask !== 16'h0080 || err_underflow !== 1'b0) begin
            errors++;
            $display("FAIL same_r7 got busy=%h err=%b exp 0080/0", busy_mask, err_underflow);
        end
        tick();
        set_in(0, 0, 0, 0, 0, 0, 1, 7, 0);
        checks++;
        if (busy_mask !== 16'h0080 || err_underflow !== 1'b0) begin
            errors++;
            $display("FAIL same_r8_zero got busy=%h err=%b exp 0080/0", busy_mask, err_underflow);
        end
        tick();
        set_idle();
        checks++;
        if (busy_mask !== 16'h0000 || err_underflow !== 1'b0) begin
            errors++;
            $display("FAIL same_clear got busy=%h err=%b exp 0000/0", busy_mask, err_underflow);
        end
    endtask

    task automatic test_underflow();
        set_in(0, 0, 0, 0, 0, 0, 1, 9, 0);
        tick();
        set_idle();
        checks++;
        if (err_underflow !== 1'b1 || busy_mask !== 16'h0000) begin
            errors++;
            $display("FAIL uf_set got err=%b busy=%h exp 1/0000", err_underflow, busy_mask);
        end
        tick();
        tick();
        checks++;
        if (err_underflow !== 1'b1) begin
            errors++; $display("FAIL uf_sticky got=%b exp=1", err_underflow);
        end
        apply_reset();
        checks++;
        if (err_underflow !== 1'b0) begin
            errors++; $display("FAIL uf_reset got=%b exp=0", err_underflow);
        end
    endtask

    task automatic test_flush();
        set_in(1, 0, 0, 0, 1, 4, 0, 0, 1);
        checks++;
        if (issue_ready !== 1'b1) begin
            errors++; $display("FAIL flush_jump_cycle_ready got=%b exp=1", issue_ready);
        end
        tick();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (flush_active !== 1'b1 || issue_ready !== 1'b0 || stall !== 1'b1) begin
            errors++;
            $display("FAIL flush_n1 got fa=%b rdy=%b st=%b exp 1/0/1",
                     flush_active, issue_ready, stall);
        end
        tick();
        set_in(1, 0, 0, 0, 0, 0, 1, 4, 0);
        checks++;
        if (flush_active !== 1'b1 || issue_ready !== 1'b0) begin
            errors++; $display("FAIL flush_n2 got fa=%b rdy=%b exp 1/0", flush_active, issue_ready);
        end
        tick();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (flush_active !== 1'b1 || busy_mask !== 16'h0000) begin
            errors++;
            $display("FAIL flush_n3 got fa=%b busy=%h exp 1/0000", flush_active, busy_mask);
        end
        tick();
        checks++;
        if (flush_active !== 1'b0 || issue_ready !== 1'b1) begin
            errors++; $display("FAIL flush_n4 got fa=%b rdy=%b exp 0/1", flush_active, issue_ready);
        end
        tick();
        set_idle();
    endtask

    task automatic test_reset_mid_flush();
        set_in(1, 0, 0, 0, 1, 2, 0, 0, 0);
        tick();
        set_in(1, 0, 0, 0, 1, 2, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        set_in(1, 2, 2, 1, 1, 2, 0, 0, 0);
        checks++;
        if (flush_active !== 1'b1 || busy_mask !== 16'h0004) begin
            errors++;
            $display("FAIL rmf_pre got fa=%b busy=%h exp 1/0004", flush_active, busy_mask);
        end
        rst_n = 1'b0;
        #1;
        m_reset();
        checks++;
        if (flush_active !== 1'b0 || busy_mask !== 16'h0000 || err_underflow !== 1'b0) begin
            errors++;
            $display("FAIL rmf_async got fa=%b busy=%h err=%b exp 0/0000/0",
                     flush_active, busy_mask, err_underflow);
        end
        checks++;
        if (issue_ready !== 1'b1 || stall !== 1'b0) begin
            errors++; $display("FAIL rmf_ready got rdy=%b st=%b exp 1/0", issue_ready, stall);
        end
        set_idle();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        set_in(0, 0, 0, 0, 0, 0, 1, 2, 0);
        tick();
        set_idle();
        checks++;
        if (err_underflow !== 1'b1) begin
            errors++; $display("FAIL rmf_stale_wb got=%b exp=1", err_underflow);
        end
        apply_reset();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            set_in(($urandom_range(0, 3) != 0) ? 1 : 0,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 1)),
                   ($urandom_range(0, 4) < 3) ? 1 : 0, int'($urandom_range(0, 3)),
                   ($urandom_range(0, 4) < 2) ? 1 : 0, int'($urandom_range(0, 3)),
                   ($urandom_range(0, 11) == 0) ? 1 : 0);
            checks++;
            if (issue_ready !== m_ready()) begin
                errors++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, issue_ready, m_ready());
            end
            checks++;
            if (stall !== (issue_valid && !m_ready())) begin
                errors++; $display("FAIL rnd_stall n=%0d got=%b", n, stall);
            end
            checks++;
            if (busy_mask !== m_busy()) begin
                errors++; $display("FAIL rnd_busy n=%0d got=%h exp=%h", n, busy_mask, m_busy());
            end
            checks++;
            if (flush_active !== m_flush()) begin
                errors++; $display("FAIL rnd_flush n=%0d got=%b exp=%b", n, flush_active, m_flush());
            end
            checks++;
            if (err_underflow !== err_m) begin
                errors++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, err_underflow, err_m);
            end
            tick();
        end
        set_idle();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        cyc   = 0;
        rst_n = 1'b0;
        m_reset();
        set_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        test_reset();
        test_raw();
        test_waw();
        test_same_cycle();
        test_underflow();
        test_flush();
        test_reset_mid_flush();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
